// File: rtl/alu_serial.sv
// Bit-serial 32-bit ALU: AND/OR/ADD/SUB/SLT/NOR, LSB first.
// Define ALU_SERIAL_2BIT_EN to process two bits per cycle.
module alu_serial (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] src1_i,
  input  logic [31:0] src2_i,
  input  logic [3:0]  ALU_control_i,
  output logic        ready_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic        zero_o,
  output logic        cout_o,
  output logic        overflow_o
);

`ifdef ALU_SERIAL_2BIT_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif
  localparam int NSTEP = 32 / STEP;
  localparam int CW = $clog2(NSTEP);
  localparam logic [CW-1:0] LAST = CW'(NSTEP - 1);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e        state_q, state_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;
  logic [31:0]   acc_q, acc_d;
  logic [3:0]    op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic [31:0]   res_q, res_d;
  logic          zero_q, zero_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;

  logic            ainv, binv;
  logic [1:0]      bop;
  logic [STEP-1:0] pa, pb, bits;
  logic [STEP:0]   c;
  logic [31:0]     acc_nx;
  logic            ovf_nx;

  // One datapath slice per processed bit; carry ripples through the slice.
  always_comb begin
    ainv = op_q[3];
    binv = op_q[2];
    bop  = op_q[1:0];
    pa   = '0;
    pb   = '0;
    bits = '0;
    c    = '0;
    c[0] = (cnt_q == '0) ? binv : carry_q;
    for (int i = 0; i < STEP; i++) begin
      pa[i]  = a_q[i] ^ ainv;
      pb[i]  = b_q[i] ^ binv;
      c[i+1] = (pa[i] & pb[i]) | (c[i] & (pa[i] ^ pb[i]));
      unique case (bop)
        2'b00:   bits[i] = pa[i] & pb[i];
        2'b01:   bits[i] = pa[i] | pb[i];
        default: bits[i] = pa[i] ^ pb[i] ^ c[i];
      endcase
    end
    acc_nx = {bits, acc_q[31:STEP]};
    ovf_nx = c[STEP-1] ^ c[STEP];
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    res_d   = res_q;
    zero_d  = zero_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          a_d     = src1_i;
          b_d     = src2_i;
          op_d    = ALU_control_i;
          acc_d   = '0;
          cnt_d   = '0;
          carry_d = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> STEP;
        b_d     = b_q >> STEP;
        acc_d   = acc_nx;
        carry_d = c[STEP];
        cnt_d   = cnt_q + CW'(1);
        // Final slice holds bit 31: results land as DONE begins.
        if (cnt_q == LAST) begin
          state_d = DONE;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          unique case (op_q)
            OP_AND, OP_OR, OP_NOR: res_d = acc_nx;
            OP_ADD, OP_SUB: begin
              res_d  = acc_nx;
              cout_d = c[STEP];
              ovf_d  = ovf_nx;
            end
            OP_SLT:  res_d = {31'b0, acc_nx[31] ^ ovf_nx};
            default: res_d = '0;
          endcase
          zero_d = (res_d == '0);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ready_o    = (state_q == IDLE);
  assign done_o     = (state_q == DONE);
  assign result_o   = res_q;
  assign zero_o     = zero_q;
  assign cout_o     = cout_q;
  assign overflow_o = ovf_q;

endmodule

// File: doc/alu_serial.md
ALU_SERIAL -- requirements
Module: alu_serial

Interface
REQ-001 The block SHALL have port clk_i, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-low, sampled on the rising edge of clk_i.
REQ-003 The block SHALL have port start_i, input, 1 bit: request a new operation; accepted only while ready_o=1.
REQ-004 The block SHALL have port src1_i, input, 32 bits: operand A, captured at acceptance.
REQ-005 The block SHALL have port src2_i, input, 32 bits: operand B, captured at acceptance.
REQ-006 The block SHALL have port ALU_control_i, input, 4 bits: opcode, captured at acceptance.
REQ-007 The block SHALL have port ready_o, output, 1 bit: idle and able to accept start_i.
REQ-008 The block SHALL have port done_o, output, 1 bit: one-cycle pulse marking result valid.
REQ-009 The block SHALL have port result_o, output, 32 bits: operation result.
REQ-010 The block SHALL have port zero_o, output, 1 bit: set when result_o is 0.
REQ-011 The block SHALL have port cout_o, output, 1 bit: carry out of bit 31 for ADD/SUB, else 0.
REQ-012 The block SHALL have port overflow_o, output, 1 bit: signed overflow for ADD/SUB, else 0.

Function
REQ-013 The block SHALL decode opcodes as: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1100 NOR.
REQ-014 For each bit, A_invert SHALL be ctrl[3], B_invert SHALL be ctrl[2], per-bit op SHALL be ctrl[1:0], and initial carry-in SHALL equal B_invert.
REQ-015 The block SHALL implement an FSM with states IDLE, RUN, DONE; ready_o=1 only in IDLE.
REQ-016 In IDLE with start_i=1, the block SHALL capture the operands and opcode, clear the bit index and carry register, and move to RUN.
REQ-017 In RUN, the block SHALL process bits LSB first, with the carry register chaining between cycles; the bit index SHALL increment per step.
REQ-018 RUN SHALL last 32 cycles in default build; after the step on bit 31, the FSM SHALL move to DONE.
REQ-019 In DONE, the block SHALL assert done_o for exactly one cycle, update result_o, zero_o, cout_o and overflow_o in that same cycle, then return to IDLE.
REQ-020 Latency SHALL be 33 cycles from the accepting edge to the done_o cycle in default build.
REQ-021 Overflow SHALL be computed as carry into bit 31 XOR carry out of bit 31.
REQ-022 For SLT, result_o SHALL be {31'b0, sum[31] XOR overflow}, with the subtraction computed serially and bit 0 patched in DONE.
REQ-023 Illegal opcodes SHALL produce result_o=0, zero_o=1, cout_o=0, overflow_o=0, with normal latency.
REQ-024 start_i SHALL be ignored in RUN and DONE; input changes after acceptance SHALL have no effect.
REQ-025 result_o and the flags SHALL hold their values until the next DONE.

Reset
REQ-026 When rst_i=0 at a clock edge, the FSM SHALL go to IDLE and all outputs SHALL clear: result_o=0, zero_o=0, cout_o=0, overflow_o=0, done_o=0, ready_o=1 the next cycle.
REQ-027 A reset during RUN or DONE SHALL abort the operation with no done_o pulse.

Configuration
REQ-028 With ALU_SERIAL_2BIT_EN defined, the block SHALL process 2 bits per cycle, with RUN lasting 16 cycles and latency of 17 cycles.
REQ-029 Without ALU_SERIAL_2BIT_EN, the block SHALL process 1 bit per cycle; results SHALL be identical in both builds.

Verification
REQ-030 ADD 0x7FFFFFFF + 0x00000001 -> after 33 cycles, done_o=1, result_o=0x80000000, overflow_o=1, cout_o=0, zero_o=0.
REQ-031 SUB 0x00000005 - 0x00000005 -> result_o=0, zero_o=1, cout_o=1, overflow_o=0.
REQ-032 SLT 0x80000000 vs 0x00000001 -> result_o=1; SLT 0x00000001 vs 0x80000000 -> result_o=0.
REQ-033 NOR 0x0F0F0F0F with 0x00FF00FF -> result_o=0xF000F000; AND/OR of the same operands -> 0x000F000F / 0x0FFF0FFF.
REQ-034 Pulse start_i mid-RUN with new operands -> ignored, original result returned; rst_i=0 at RUN cycle 10 -> no done_o, ready_o=1 and result_o=0 next cycle.
REQ-035 With ALU_SERIAL_2BIT_EN defined, rerun REQ-030 -> same values, with done_o arriving 17 cycles after acceptance.
